xor_checksum_unit: RTL and testbench
====================================

// Module: xor_checksum_unit
// PURPOSE
//  Parametrised, registered successor to the 2-input XOR gate: folds a stream of DATA_W-bit words
//  into one XOR checksum per frame. Counts beats and flags frames longer than MAX_LEN.
//  Sits between a valid/ready word source and a checksum consumer (integrity checks in datapath labs).
// PARAMETERS
//  DATA_W   8   width of input words and checksum
//  MAX_LEN  16  max legal beats per frame; length counter saturates here (CNT_W = $clog2(MAX_LEN+1))
//  INIT_VAL 0   seed XORed into the first beat of every frame (DATA_W bits)
// PORTS
//  clk_in      in   1       single clock, rising edge
//  rst_in      in   1       asynchronous, active-high reset
//  s_valid_in  in   1       input beat valid
//  s_ready_out out  1       unit can accept a beat
//  s_data_in   in   DATA_W  input word
//  s_last_in   in   1       beat is last of frame
//  m_valid_out out  1       checksum result valid
//  m_ready_in  in   1       consumer accepts result
//  m_sum_out   out  DATA_W  XOR checksum of frame
//  m_len_out   out  CNT_W   beats in frame, saturated at MAX_LEN
//  m_ovf_out   out  1       frame exceeded MAX_LEN beats
//  exp_in      in   DATA_W  expected checksum, only with XOR_CHK_COMPARE_EN
//  m_err_out   out  1       checksum mismatch, only with XOR_CHK_COMPARE_EN
// BEHAVIOUR
//  - Reset (async, rst_in=1): state IDLE, acc/cnt/ovf=0. Outputs: s_ready_out=0 while rst_in high, else 1.
//    m_valid_out=0, m_sum_out=0, m_len_out=0, m_ovf_out=0, m_err_out=0. A partial frame is discarded.
//  - Beat accepted when s_valid_in && s_ready_out at rising clk_in. s_ready_out = (state != HOLD).
//  - FSM:
//      IDLE  -> ACCUM on accepted beat with !s_last_in; IDLE -> HOLD on accepted beat with s_last_in.
//      ACCUM -> HOLD on accepted beat with s_last_in.
//      HOLD  -> IDLE when m_ready_in=1.
//  - Accumulate: first beat acc = INIT_VAL ^ s_data_in; later beats acc = acc ^ s_data_in.
//    cnt increments per beat, saturating at MAX_LEN. ovf is set on any beat accepted while cnt==MAX_LEN;
//    it stays set until end of frame. acc keeps folding every beat, including beats past overflow.
//  - Result timing: m_valid_out rises the cycle after the last beat (latency 1).
//    m_sum_out/m_len_out/m_ovf_out are registered and stable while in HOLD.
//  - Result outputs hold their last values in IDLE/ACCUM; only m_valid_out qualifies them.
//  - Backpressure: while HOLD && !m_ready_in, everything is frozen and no beats are accepted.
//    There is one bubble cycle per frame: no beat is accepted in the cycle m_ready_in retires the result.
//  - s_valid_in low mid-frame: the unit waits in ACCUM indefinitely with no timeout.
//  - Data and last are ignored when s_valid_in=0 or s_ready_out=0.
// CONFIGURATION
//  XOR_CHK_COMPARE_EN defined:
//    exp_in and m_err_out ports exist. exp_in is sampled with the last beat.
//    m_err_out = (final sum != exp_in), registered with m_sum_out and valid with m_valid_out.
//  XOR_CHK_COMPARE_EN undefined: exp_in and m_err_out are absent; no compare logic.
// TESTING (DATA_W=8, MAX_LEN=4, INIT_VAL=0)
//  1. Assert rst_in while idle, then mid-frame after 2 beats
//     -> all outputs 0 immediately, without waiting for clk_in; a following frame 0x11 last gives sum 0x11, len 1.
//  2. Frame 0xA5, 0x3C, 0xFF(last), back-to-back, m_ready_in=1
//     -> m_valid_out 1 the cycle after the last beat, sum 0x66, len 3, ovf 0.
//  3. Single-beat frame 0x5A(last) -> sum 0x5A, len 1; with INIT_VAL=0xFF, sum 0xA5.
//  4. Frame 2 completes, m_ready_in held 0 for 5 cycles with s_valid_in=1
//     -> m_valid_out 1 and outputs stable, s_ready_out 0, no beat accepted; released -> IDLE next cycle.
//  5. Six beats of 0x01, last on the 6th -> len 4 (saturated), ovf 1, sum 0x00.
//  6. XOR_CHK_COMPARE_EN, frame from test 2: exp_in=0x66 -> m_err_out 0; exp_in=0x67 -> m_err_out 1.

Source files
------------

// File: rtl/xor_checksum_unit.sv
// Streaming XOR checksum: folds valid/ready beats into one sum per frame and counts the beats.
// Optional expected-sum compare is built when XOR_CHK_COMPARE_EN is defined.
module xor_checksum_unit #(
   parameter int unsigned       DATA_W   = 8,
   parameter int unsigned       MAX_LEN  = 16,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic                             s_valid_in,
   output logic                             s_ready_out,
   input  logic [DATA_W-1:0]                s_data_in,
   input  logic                             s_last_in,
   output logic                             m_valid_out,
   input  logic                             m_ready_in,
   output logic [DATA_W-1:0]                m_sum_out,
   output logic [$clog2(MAX_LEN+1)-1:0]     m_len_out,
`ifdef XOR_CHK_COMPARE_EN
   input  logic [DATA_W-1:0]                exp_in,
   output logic                             m_err_out,
`endif
   output logic                             m_ovf_out
);

   localparam int unsigned CntW = $clog2(MAX_LEN + 1);
   localparam logic [CntW-1:0] MaxCnt = CntW'(MAX_LEN);

   typedef enum logic [1:0] {StIdle, StAccum, StHold} state_e;

   state_e state_q, state_d;

   logic [DATA_W-1:0] acc_q, acc_d, acc_base;
   logic [CntW-1:0]   cnt_q, cnt_d, cnt_base;
   logic              ovf_q, ovf_d, ovf_base;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [CntW-1:0]   len_q, len_d;
   logic              rovf_q, rovf_d;
   logic              beat_acc;
   logic              at_max;
`ifdef XOR_CHK_COMPARE_EN
   logic              err_q, err_d;
`endif

   // State register
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (beat_acc) state_d = s_last_in ? StHold : StAccum;
         end
         StAccum: begin
            if (beat_acc && s_last_in) state_d = StHold;
         end
         StHold: begin
            if (m_ready_in) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Handshake outputs; ready is forced low while reset is held
   always_comb begin
      s_ready_out = !rst_in && (state_q != StHold);
      m_valid_out = (state_q == StHold);
   end

   assign beat_acc = s_valid_in && s_ready_out;

   // First beat of a frame starts from the seed and a clear count
   always_comb begin
      acc_base = (state_q == StIdle) ? INIT_VAL : acc_q;
      cnt_base = (state_q == StIdle) ? '0 : cnt_q;
      ovf_base = (state_q == StIdle) ? 1'b0 : ovf_q;
      at_max   = (cnt_base == MaxCnt);

      acc_d  = acc_q;
      cnt_d  = cnt_q;
      ovf_d  = ovf_q;
      sum_d  = sum_q;
      len_d  = len_q;
      rovf_d = rovf_q;
`ifdef XOR_CHK_COMPARE_EN
      err_d  = err_q;
`endif
      if (beat_acc) begin
         acc_d = acc_base ^ s_data_in;
         cnt_d = at_max ? MaxCnt : cnt_base + CntW'(1);
         ovf_d = ovf_base | at_max;
         if (s_last_in) begin
            sum_d  = acc_d;
            len_d  = cnt_d;
            rovf_d = ovf_d;
`ifdef XOR_CHK_COMPARE_EN
            err_d  = (acc_d != exp_in);
`endif
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         acc_q  <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         sum_q  <= '0;
         len_q  <= '0;
         rovf_q <= 1'b0;
`ifdef XOR_CHK_COMPARE_EN
         err_q  <= 1'b0;
`endif
      end else begin
         acc_q  <= acc_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         sum_q  <= sum_d;
         len_q  <= len_d;
         rovf_q <= rovf_d;
`ifdef XOR_CHK_COMPARE_EN
         err_q  <= err_d;
`endif
      end
   end

   assign m_sum_out = sum_q;
   assign m_len_out = len_q;
   assign m_ovf_out = rovf_q;
`ifdef XOR_CHK_COMPARE_EN
   assign m_err_out = err_q;
`endif

endmodule

// File: tb/tb_xor_checksum_unit.sv
// Directed bench for xor_checksum_unit (DATA_W=8, MAX_LEN=4); a second instance uses INIT_VAL=0xFF.
module tb_xor_checksum_unit;

   logic       clk;
   logic       rst;
   logic       s_valid;
   logic [7:0] s_data;
   logic       s_last;
   logic       m_ready;
   logic       s_ready, m_valid, m_ovf;
   logic [7:0] m_sum;
   logic [2:0] m_len;
   logic       s_ready2, m_valid2, m_ovf2;
   logic [7:0] m_sum2;
   logic [2:0] m_len2;
`ifdef XOR_CHK_COMPARE_EN
   logic [7:0] exp_val;
   logic       m_err, m_err2;
`endif

   int checks = 0;
   int errors = 0;

   xor_checksum_unit #(.DATA_W(8), .MAX_LEN(4), .INIT_VAL(8'h00)) dut (
      .clk_in     (clk),
      .rst_in     (rst),
      .s_valid_in (s_valid),
      .s_ready_out(s_ready),
      .s_data_in  (s_data),
      .s_last_in  (s_last),
      .m_valid_out(m_valid),
      .m_ready_in (m_ready),
      .m_sum_out  (m_sum),
      .m_len_out  (m_len),
`ifdef XOR_CHK_COMPARE_EN
      .exp_in     (exp_val),
      .m_err_out  (m_err),
`endif
      .m_ovf_out  (m_ovf)
   );

   xor_checksum_unit #(.DATA_W(8), .MAX_LEN(4), .INIT_VAL(8'hFF)) dut_seed (
      .clk_in     (clk),
      .rst_in     (rst),
      .s_valid_in (s_valid),
      .s_ready_out(s_ready2),
      .s_data_in  (s_data),
      .s_last_in  (s_last),
      .m_valid_out(m_valid2),
      .m_ready_in (m_ready),
      .m_sum_out  (m_sum2),
      .m_len_out  (m_len2),
`ifdef XOR_CHK_COMPARE_EN
      .exp_in     (exp_val),
      .m_err_out  (m_err2),
`endif
      .m_ovf_out  (m_ovf2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one beat at a negedge; it is taken at the next posedge. Returns at the following negedge.
   task automatic beat(input logic [7:0] d, input logic l);
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
`ifdef XOR_CHK_COMPARE_EN
      exp_val = '0;
`endif
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({s_ready, m_valid, m_sum, m_len, m_ovf} !== 13'h0) begin
         errors++;
         $display("FAIL reset_idle got %h exp 0", {s_ready, m_valid, m_sum, m_len, m_ovf});
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++;
      if (s_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready got %b exp 1", s_ready);
      end
      @(negedge clk);
      beat(8'h22, 1'b1);
      @(negedge clk);
      beat(8'h0F, 1'b0);
      beat(8'hF0, 1'b0);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({s_ready, m_valid, m_sum, m_len, m_ovf} !== 13'h0) begin
         errors++;
         $display("FAIL reset_midframe got %h exp 0", {s_ready, m_valid, m_sum, m_len, m_ovf});
      end
      @(negedge clk);
      rst = 1'b0;
      beat(8'h11, 1'b1);
      checks++;
      if ({m_valid, m_sum, m_len} !== {1'b1, 8'h11, 3'd1}) begin
         errors++;
         $display("FAIL reset_next_frame got v%b %h len %0d exp v1 11 len 1", m_valid, m_sum, m_len);
      end
      @(negedge clk);
   endtask

   task automatic test_frame();
      beat(8'hA5, 1'b0);
      beat(8'h3C, 1'b0);
      checks++;
      if (m_valid !== 1'b0) begin
         errors++; $display("FAIL frame_early_valid got %b exp 0", m_valid);
      end
      beat(8'hFF, 1'b1);
      checks++;
      if ({m_valid, m_sum, m_len, m_ovf} !== {1'b1, 8'h66, 3'd3, 1'b0}) begin
         errors++;
         $display("FAIL frame_3beat got v%b %h len %0d ovf %b exp v1 66 len 3 ovf 0",
                  m_valid, m_sum, m_len, m_ovf);
      end
      @(negedge clk);
      checks++;
      if ({m_valid, s_ready} !== 2'b01) begin
         errors++; $display("FAIL frame_retire got v%b r%b exp v0 r1", m_valid, s_ready);
      end
   endtask

   task automatic test_single_beat();
      beat(8'h5A, 1'b1);
      checks++;
      if ({m_valid, m_sum, m_len} !== {1'b1, 8'h5A, 3'd1}) begin
         errors++;
         $display("FAIL single_beat got v%b %h len %0d exp v1 5a len 1", m_valid, m_sum, m_len);
      end
      checks++;
      if ({m_valid2, m_sum2, m_len2} !== {1'b1, 8'hA5, 3'd1}) begin
         errors++;
         $display("FAIL single_seed got v%b %h len %0d exp v1 a5 len 1", m_valid2, m_sum2, m_len2);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      m_ready = 1'b0;
      beat(8'h12, 1'b0);
      beat(8'h34, 1'b1);
      s_valid = 1'b1; s_data = 8'h99; s_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({m_valid, s_ready, m_sum, m_len} !== {1'b1, 1'b0, 8'h26, 3'd2}) begin
            errors++;
            $display("FAIL backpressure_hold[%0d] got v%b r%b %h len %0d exp v1 r0 26 len 2",
                     i, m_valid, s_ready, m_sum, m_len);
         end
         @(negedge clk);
      end
      s_valid = 1'b0; s_last = 1'b0;
      m_ready = 1'b1;
      @(negedge clk);
      checks++;
      if ({m_valid, s_ready} !== 2'b01) begin
         errors++; $display("FAIL backpressure_release got v%b r%b exp v0 r1", m_valid, s_ready);
      end
      beat(8'h01, 1'b1);
      checks++;
      if ({m_sum, m_len} !== {8'h01, 3'd1}) begin
         errors++; $display("FAIL backpressure_after got %h len %0d exp 01 len 1", m_sum, m_len);
      end
      @(negedge clk);
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 6; i++) beat(8'h01, (i == 5));
      checks++;
      if ({m_valid, m_sum, m_len, m_ovf} !== {1'b1, 8'h00, 3'd4, 1'b1}) begin
         errors++;
         $display("FAIL sat_6beat got v%b %h len %0d ovf %b exp v1 00 len 4 ovf 1",
                  m_valid, m_sum, m_len, m_ovf);
      end
      @(negedge clk);
      for (int i = 0; i < 4; i++) beat(8'h01 << i, (i == 3));
      checks++;
      if ({m_sum, m_len, m_ovf} !== {8'h0F, 3'd4, 1'b0}) begin
         errors++;
         $display("FAIL sat_exact4 got %h len %0d ovf %b exp 0f len 4 ovf 0", m_sum, m_len, m_ovf);
      end
      @(negedge clk);
      for (int i = 0; i < 5; i++) beat(8'h01 << i, (i == 4));
      checks++;
      if ({m_sum, m_len, m_ovf} !== {8'h1F, 3'd4, 1'b1}) begin
         errors++;
         $display("FAIL sat_fold5 got %h len %0d ovf %b exp 1f len 4 ovf 1", m_sum, m_len, m_ovf);
      end
      @(negedge clk);
      beat(8'h77, 1'b1);
      checks++;
      if ({m_sum, m_len, m_ovf} !== {8'h77, 3'd1, 1'b0}) begin
         errors++;
         $display("FAIL sat_clear got %h len %0d ovf %b exp 77 len 1 ovf 0", m_sum, m_len, m_ovf);
      end
      @(negedge clk);
   endtask

   task automatic test_idle_gaps();
      beat(8'hC3, 1'b0);
      s_data = 8'hEE; s_last = 1'b1;
      repeat (3) @(negedge clk);
      beat(8'h81, 1'b1);
      checks++;
      if ({m_valid, m_sum, m_len} !== {1'b1, 8'h42, 3'd2}) begin
         errors++;
         $display("FAIL idle_gap got v%b %h len %0d exp v1 42 len 2", m_valid, m_sum, m_len);
      end
      @(negedge clk);
   endtask

`ifdef XOR_CHK_COMPARE_EN
   task automatic test_compare();
      exp_val = 8'h66;
      beat(8'hA5, 1'b0);
      beat(8'h3C, 1'b0);
      beat(8'hFF, 1'b1);
      checks++;
      if (m_err !== 1'b0) begin
         errors++; $display("FAIL cmp_match got %b exp 0", m_err);
      end
      @(negedge clk);
      exp_val = 8'h67;
      beat(8'hA5, 1'b0);
      beat(8'h3C, 1'b0);
      beat(8'hFF, 1'b1);
      checks++;
      if (m_err !== 1'b1) begin
         errors++; $display("FAIL cmp_mismatch got %b exp 1", m_err);
      end
      @(negedge clk);
   endtask
`endif

   initial begin
      test_reset();
      test_frame();
      test_single_beat();
      test_backpressure();
      test_saturation();
      test_idle_gaps();
`ifdef XOR_CHK_COMPARE_EN
      test_compare();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
